tdm_demux_4ch: RTL and testbench
================================

# tdm_demux_4ch

Four-channel time-division demultiplexer: receives a single serial TDM line carrying four W-bit channel samples per frame, plus a frame-sync marker. It reconstructs the four parallel samples and presents them together with a one-cycle frame-valid strobe. It is the receive-side counterpart to the 4-to-1 channel selection used in the ch4 mux exercises. It sits between a serial link input and per-channel parallel consumers.

## Interface
- W, 4, bits per channel sample (2..16)
- MISS_MAX, 2, consecutive missing syncs tolerated before loss of lock (1..7)
- clock  input  1  rising-edge clock
- reset_b  input  1  asynchronous, active-low reset
- bit_en  input  1  bit strobe; din/sync sampled only on edges where bit_en=1
- din  input  1  serial data, MSB of each slot first, slot 0 first
- sync  input  1  high coincident with MSB of slot 0
- ch0, ch1, ch2, ch3  output  W each  last complete frame's samples
- frame_valid  output  1  one-cycle pulse when ch0..ch3 update
- locked  output  1  high while in LOCKED state
- sync_err  output  1  one-cycle pulse on misplaced or missing sync

## Operation
- Frame = 4*W bits; bit index b = 0..4W-1; slot = b / W, bit-in-slot = b mod W.
- States: HUNT (reset state), LOCKED.
- HUNT: din ignored until sampled sync=1; that bit is taken as b=0, go LOCKED, miss count = 0.
- LOCKED, each sampled bit: shift din into slot shift register; at bit-in-slot W-1 copy the assembled sample into staging[slot].
- At b=4W-1: ch0..ch3 <= staging[0..2] and the just-completed slot 3 sample, all simultaneously; frame_valid pulses; b wraps to 0.
- Sync checking in LOCKED:
  - sync=1 at b=0: miss count cleared.
  - sync=0 at b=0: sync_err pulses, miss count +1; frame continues on the flywheel; if count reaches MISS_MAX -> HUNT, locked=0, partial frame discarded.
  - sync=1 at b!=0: sync_err pulses; partial frame discarded (no frame_valid, ch unchanged); this bit becomes b=0; miss count cleared; stay LOCKED.
- ch0..ch3 change only with frame_valid; otherwise hold.
- bit_en=0: no state, counter, or shift change; pulses do not fire.

## Timing
- Reset (async assert): state HUNT, counters 0, ch0..ch3 = 0, frame_valid = 0, locked = 0, sync_err = 0. Reset mid-frame drops the frame.
- locked rises on the edge sampling the first valid sync.
- frame_valid and the new ch values are registered on the edge sampling b=4W-1. They are visible the following cycle; frame_valid is high exactly one clock.
- sync_err is registered on the edge sampling the offending bit; one clock wide.
- Back-to-back frames with bit_en tied high give frame_valid every 4W clocks.

## Structure
- Package tdm_pkg: NCH=4, state encodings HUNT/LOCKED, helper for counter width clog2(4*W).
- Sub-module tdm_slot_counter: bit-in-slot and slot counters with wrap, load-to-zero on resync, terminal-count outputs.
- Top holds the FSM, shift register, staging registers, and output registers.

## Test plan
- W=4, reset then bit_en=1, stream frames 0xA,0x5,0xF,0x3 with correct sync -> locked=1 after first sync bit; frame_valid every 16 clocks; ch0..3 = A,5,F,3.
- Data before first sync (8 random bits) -> no frame_valid, locked=0, ch all 0.
- Sync removed for one frame (MISS_MAX=2) -> one sync_err, frame still delivered, locked stays 1; two consecutive misses -> locked=0 at second frame start, no frame_valid.
- Extra sync at b=6 -> sync_err pulse, that frame dropped, ch hold previous values; next frame aligned to new sync decodes correctly.
- bit_en high every 3rd clock -> same decoded values as with bit_en tied high; frame_valid every 48 clocks, one clock wide.
- reset_b low mid-frame (b=9) -> all outputs 0 immediately; resumes only after next sync.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and types for the four-channel TDM receive path.
package tdm_pkg;

  localparam int NCH = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Width of a counter spanning one whole frame of NCH*w bits.
  function automatic int cnt_width(input int w);
    return $clog2(NCH * w);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Frame position tracker: bit-in-slot and slot counters with wrap,
// resync-to-frame-start and terminal-count flags.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                       clock,
  input  logic                       reset_b,
  input  logic                       adv,
  input  logic                       resync,
  input  logic                       clr,
  output logic [$clog2(NCH)-1:0]     slot_idx,
  output logic                       at_zero,
  output logic                       slot_tc,
  output logic                       frame_tc
);

  localparam int SLOT_W = $clog2(NCH);
  localparam int BIS_W  = cnt_width(W) - SLOT_W;

  logic [BIS_W-1:0]  bis_q, bis_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  assign slot_tc  = (bis_q == BIS_W'(W - 1));
  assign frame_tc = slot_tc && (slot_q == SLOT_W'(NCH - 1));
  assign at_zero  = (bis_q == '0) && (slot_q == '0);
  assign slot_idx = slot_q;

  // resync means the bit being sampled now is b=0, so the next bit is b=1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bis_d  = bis_q;
    slot_d = slot_q;
    if (clr) begin
      bis_d  = '0;
      slot_d = '0;
    end else if (resync) begin
      bis_d  = BIS_W'(1);
      slot_d = '0;
    end else if (adv) begin
      if (slot_tc) begin
        bis_d  = '0;
        slot_d = slot_q + SLOT_W'(1);
      end else begin
        bis_d  = bis_q + BIS_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      bis_q  <= '0;
      slot_q <= '0;
    end else begin
      bis_q  <= bis_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: sync hunting/flywheel FSM, sample
// assembly, staging and simultaneous parallel output update.
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int W        = 4,
  parameter int MISS_MAX = 2
) (
  input  logic         clock,
  input  logic         reset_b,
  input  logic         bit_en,
  input  logic         din,
  input  logic         sync,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err
);

  localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);

  state_e                   state_q, state_d;
  logic [2:0]               miss_q, miss_d;
  logic [W-1:0]             shift_q, shift_d;
  logic [W-1:0]             stage_q [NCH-1];
  logic [W-1:0]             stage_d [NCH-1];
  logic [W-1:0]             ch_q [NCH];
  logic [W-1:0]             ch_d [NCH];
  logic                     fv_q, fv_d;
  logic                     err_q, err_d;

  logic                     cnt_adv, cnt_resync, cnt_clr;
  logic [$clog2(NCH)-1:0]   slot_idx;
  logic                     at_zero, slot_tc, frame_tc;
  logic [W-1:0]             sample;

  tdm_slot_counter #(.W(W)) u_cnt (
    .clock    (clock),
    .reset_b  (reset_b),
    .adv      (cnt_adv),
    .resync   (cnt_resync),
    .clr      (cnt_clr),
    .slot_idx (slot_idx),
    .at_zero  (at_zero),
    .slot_tc  (slot_tc),
    .frame_tc (frame_tc)
  );

  assign sample = {shift_q[W-2:0], din};

  always_comb begin
    state_d    = state_q;
    miss_d     = miss_q;
    shift_d    = shift_q;
    stage_d    = stage_q;
    ch_d       = ch_q;
    fv_d       = 1'b0;
    err_d      = 1'b0;
    cnt_adv    = 1'b0;
    cnt_resync = 1'b0;
    cnt_clr    = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            state_d    = LOCKED;
            miss_d     = '0;
            shift_d    = sample;
            cnt_resync = 1'b1;
          end
        end
        LOCKED: begin
          if (sync && !at_zero) begin
            // Misplaced sync: drop the partial frame and realign on this bit.
            err_d      = 1'b1;
            miss_d     = '0;
            shift_d    = sample;
            cnt_resync = 1'b1;
          end else if (!sync && at_zero && (({1'b0, miss_q} + 4'd1) >= MISS_LIM)) begin
            err_d   = 1'b1;
            miss_d  = '0;
            state_d = HUNT;
            cnt_clr = 1'b1;
          end else begin
            if (at_zero) begin
              miss_d = sync ? 3'd0 : miss_q + 3'd1;
              err_d  = !sync;
            end
            shift_d = sample;
            cnt_adv = 1'b1;
            for (int i = 0; i < NCH - 1; i++) begin
              if (slot_tc && (slot_idx == 2'(i))) stage_d[i] = sample;
            end
            if (frame_tc) begin
              for (int i = 0; i < NCH - 1; i++) ch_d[i] = stage_q[i];
              ch_d[NCH-1] = sample;
              fv_d        = 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= HUNT;
      miss_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) ch_q[i] <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      ch_q    <= ch_d;
    end
  end

  // NOTE: shift and staging need no reset: every bit is overwritten after a
  // sync before any of it can reach ch0..ch3.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
    stage_q <= stage_d;
  end

  assign ch0         = ch_q[0];
  assign ch1         = ch_q[1];
  assign ch2         = ch_q[2];
  assign ch3         = ch_q[3];
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Scoreboard bench for tdm_demux_4ch: expected frames are queued as they
// are driven and popped when frame_valid fires.
module tb_tdm_demux_4ch;
  import tdm_pkg::*;

  localparam int W        = 4;
  localparam int MISS_MAX = 2;

  typedef logic [NCH-1:0][W-1:0] frame_t;

  logic         clock;
  logic         reset_b;
  logic         bit_en;
  logic         din;
  logic         sync;
  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic         frame_valid;
  logic         locked;
  logic         sync_err;
  logic [W-1:0] ch_out [NCH];

  frame_t sb[$];
  frame_t last_frame;
  int     n_total = 0;
  int     n_bad   = 0;
  int     cyc     = 0;
  int     fv_cnt  = 0;
  int     err_cnt = 0;
  int     exp_period = 0;
  int     seg     = 0;
  logic   lock_after_first;

  tdm_demux_4ch #(.W(W), .MISS_MAX(MISS_MAX)) dut (
    .clock       (clock),
    .reset_b     (reset_b),
    .bit_en      (bit_en),
    .din         (din),
    .sync        (sync),
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  assign ch_out[0] = ch0;
  assign ch_out[1] = ch1;
  assign ch_out[2] = ch2;
  assign ch_out[3] = ch3;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic frame_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] d);
    frame_t f;
    f[0] = a; f[1] = b; f[2] = c; f[3] = d;
    return f;
  endfunction

  function automatic frame_t rnd_frame();
    frame_t f;
    for (int c = 0; c < NCH; c++) f[c] = W'($urandom);
    return f;
  endfunction

  // Drives bits first..first+n-1 of a frame, one bit_en cycle per bit plus gap idle clocks.
  task automatic send_bits(input frame_t f, input int first, input int n,
                           input bit sync_first, input int gap);
    for (int i = first; i < first + n; i++) begin
      int slot;
      int bis;
      slot   = i / W;
      bis    = i % W;
      bit_en = 1'b1;
      din    = f[slot][W-1-bis];
      sync   = (i == 0) && sync_first;
      @(posedge clock);
      #1;
      if (i == first) lock_after_first = locked;
      bit_en = 1'b0;
      sync   = 1'b0;
      repeat (gap) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic send_frame(input frame_t f, input bit sync_ok, input bit expect_out,
                            input int gap);
    if (expect_out) begin
      sb.push_back(f);
      last_frame = f;
    end
    send_bits(f, 0, NCH * W, sync_ok, gap);
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every frame_valid.
  initial begin
    logic   prev_fv;
    int     last_cyc;
    int     my_seg;
    frame_t e;
    prev_fv  = 1'b0;
    last_cyc = -1;
    my_seg   = -1;
    forever begin
      @(negedge clock);
      if (sync_err) err_cnt++;
      if (seg != my_seg) begin
        my_seg   = seg;
        last_cyc = -1;
      end
      if (frame_valid) begin
        fv_cnt++;
        check("fv_width", 32'(prev_fv), 32'd0);
        if (exp_period != 0 && last_cyc >= 0)
          check("fv_period", 32'(cyc - last_cyc), 32'(exp_period));
        last_cyc = cyc;
        if (sb.size() == 0) begin
          check("fv_unexpected", 32'(frame_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          for (int c = 0; c < NCH; c++)
            check($sformatf("ch%0d", c), 32'(ch_out[c]), 32'(e[c]));
        end
      end
      prev_fv = frame_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    reset_b = 1'b0;
    bit_en  = 1'b0;
    din     = 1'b0;
    sync    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int c = 0; c < NCH; c++) check($sformatf("rst_ch%0d", c), 32'(ch_out[c]), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(sync_err), 32'd0);
    reset_b = 1'b1;
    @(posedge clock);
    #1;

    // Data with no sync is ignored.
    send_bits(rnd_frame(), 0, 8, 1'b0, 0);
    settle();
    check("hunt_locked", 32'(locked), 32'd0);
    check("hunt_fv_cnt", 32'(fv_cnt), 32'd0);
    check("hunt_ch0", 32'(ch0), 32'd0);

    // Lock and stream back-to-back frames.
    seg = 1;
    exp_period = 16;
    send_frame(mk(4'hA, 4'h5, 4'hF, 4'h3), 1'b1, 1'b1, 0);
    check("lock_first_bit", 32'(lock_after_first), 32'd1);
    send_frame(mk(4'h1, 4'h2, 4'h3, 4'h4), 1'b1, 1'b1, 0);
    send_frame(rnd_frame(), 1'b1, 1'b1, 0);
    settle();
    check("lock_drain", 32'(sb.size()), 32'd0);
    check("lock_fv_cnt", 32'(fv_cnt), 32'd3);
    check("lock_locked", 32'(locked), 32'd1);

    // One missing sync rides the flywheel.
    e0 = err_cnt;
    send_frame(mk(4'h6, 4'h7, 4'h8, 4'h9), 1'b0, 1'b1, 0);
    send_frame(mk(4'h0, 4'hF, 4'h0, 4'hF), 1'b1, 1'b1, 0);
    settle();
    check("miss1_err", 32'(err_cnt - e0), 32'd1);
    check("miss1_locked", 32'(locked), 32'd1);
    check("miss1_drain", 32'(sb.size()), 32'd0);

    // Two consecutive misses drop lock at the second frame start.
    send_frame(rnd_frame(), 1'b0, 1'b1, 0);
    send_frame(rnd_frame(), 1'b0, 1'b0, 0);
    check("miss2_unlock", 32'(lock_after_first), 32'd0);
    settle();
    check("miss2_err", 32'(err_cnt - e0), 32'd3);
    check("miss2_locked", 32'(locked), 32'd0);
    check("miss2_fv_cnt", 32'(fv_cnt), 32'd6);

    // Relock, then an extra sync at b=6 drops the partial frame.
    seg = 3;
    exp_period = 0;
    send_frame(mk(4'hC, 4'hD, 4'hE, 4'hB), 1'b1, 1'b1, 0);
    send_bits(rnd_frame(), 0, 6, 1'b1, 0);
    for (int c = 0; c < NCH; c++)
      check($sformatf("hold_ch%0d", c), 32'(ch_out[c]), 32'(last_frame[c]));
    e0 = err_cnt;
    send_frame(mk(4'h2, 4'h4, 4'h6, 4'h8), 1'b1, 1'b1, 0);
    settle();
    check("resync_err", 32'(err_cnt - e0), 32'd1);
    check("resync_drain", 32'(sb.size()), 32'd0);
    check("resync_fv_cnt", 32'(fv_cnt), 32'd8);

    // Bit strobe every third clock.
    seg = 4;
    exp_period = 48;
    send_frame(mk(4'hA, 4'h5, 4'hF, 4'h3), 1'b1, 1'b1, 2);
    send_frame(mk(4'h0, 4'h9, 4'h1, 4'hE), 1'b1, 1'b1, 2);
    send_frame(mk(4'hB, 4'hC, 4'hD, 4'hE), 1'b1, 1'b1, 2);
    settle();
    check("gap_drain", 32'(sb.size()), 32'd0);
    check("gap_fv_cnt", 32'(fv_cnt), 32'd11);

    // Reset in the middle of a frame.
    seg = 5;
    exp_period = 0;
    send_bits(rnd_frame(), 0, 9, 1'b1, 0);
    reset_b = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++) check($sformatf("mid_rst_ch%0d", c), 32'(ch_out[c]), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_fv", 32'(frame_valid), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_b = 1'b1;
    send_bits(rnd_frame(), 0, 8, 1'b0, 0);
    check("post_rst_hunt", 32'(locked), 32'd0);
    send_frame(mk(4'h7, 4'h3, 4'h1, 4'h5), 1'b1, 1'b1, 0);
    settle();
    check("post_rst_drain", 32'(sb.size()), 32'd0);
    check("post_rst_fv_cnt", 32'(fv_cnt), 32'd12);
    check("post_rst_locked", 32'(locked), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
